alu_rs_scheduler: RTL and testbench

Reservation-station scheduler for the integer execute unit in the out-of-order core. It buffers dispatched ALU/branch/jump instructions and snoops both result buses for operand wakeup. Each cycle it picks one ready entry, drives the combinational EX unit through an issue register, and broadcasts the registered EX result (value, jump target, ROB tag) on the ALU result bus.

---
 rtl/alu_rs_scheduler.sv | 251 +++++++++++++++++++++++++
 tb/tb_alu_rs_scheduler.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs_scheduler.sv
// Integer reservation station: buffers ALU/branch ops, wakes operands from both result buses,
// issues the lowest-index ready entry each cycle into the EX issue register and broadcasts results.
module alu_rs_scheduler #(
    parameter int RS_SIZE = 16,
    parameter int TAG_W   = 4,
    parameter int TYPE_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [TYPE_W-1:0] in_type,
    input  logic              in_qj_busy,
    input  logic              in_qk_busy,
    input  logic [TAG_W-1:0]  in_qj,
    input  logic [TAG_W-1:0]  in_qk,
    input  logic [31:0]       in_vj,
    input  logic [31:0]       in_vk,
    input  logic [31:0]       in_A,
    input  logic [31:0]       in_pc,
    input  logic [TAG_W-1:0]  in_dest,
    output logic              full,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [31:0]       cdb_value,
    output logic [TYPE_W-1:0] ex_type,
    output logic [31:0]       ex_vj,
    output logic [31:0]       ex_vk,
    output logic [31:0]       ex_A,
    output logic [31:0]       ex_pc,
    input  logic [31:0]       ex_value,
    input  logic [31:0]       ex_jumppc,
    output logic              out_valid,
    output logic [TAG_W-1:0]  out_tag,
    output logic [31:0]       out_value,
    output logic [31:0]       out_jumppc
);

    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    // Entry storage
    logic [RS_SIZE-1:0] r_busy;
    logic [RS_SIZE-1:0] r_qj_busy;
    logic [RS_SIZE-1:0] r_qk_busy;
    logic [TYPE_W-1:0]  r_type [RS_SIZE];
    logic [TAG_W-1:0]   r_qj   [RS_SIZE];
    logic [TAG_W-1:0]   r_qk   [RS_SIZE];
    logic [31:0]        r_vj   [RS_SIZE];
    logic [31:0]        r_vk   [RS_SIZE];
    logic [31:0]        r_A    [RS_SIZE];
    logic [31:0]        r_pc   [RS_SIZE];
    logic [TAG_W-1:0]   r_dest [RS_SIZE];

    // Issue register
    logic              r_iss_valid;
    logic [TAG_W-1:0]  r_iss_dest;
    logic [TYPE_W-1:0] r_ex_type;
    logic [31:0]       r_ex_vj;
    logic [31:0]       r_ex_vk;
    logic [31:0]       r_ex_A;
    logic [31:0]       r_ex_pc;

    // Result bus
    logic              r_out_valid;
    logic [TAG_W-1:0]  r_out_tag;
    logic [31:0]       r_out_value;
    logic [31:0]       r_out_jumppc;

    logic [RS_SIZE-1:0] w_ready;
    logic [RS_SIZE-1:0] w_j_cdb;
    logic [RS_SIZE-1:0] w_j_out;
    logic [RS_SIZE-1:0] w_k_cdb;
    logic [RS_SIZE-1:0] w_k_out;
    logic               w_free_found;
    logic [IDX_W-1:0]   w_free_idx;
    logic               w_sel_found;
    logic [IDX_W-1:0]   w_sel_idx;
    logic               w_in_qj_busy;
    logic               w_in_qk_busy;
    logic [31:0]        w_in_vj;
    logic [31:0]        w_in_vk;
    logic               w_insert;

    assign w_ready  = r_busy & ~r_qj_busy & ~r_qk_busy;
    assign full     = &r_busy;
    assign w_insert = in_valid & w_free_found;

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            w_j_cdb[i] = cdb_valid   && (cdb_tag   == r_qj[i]);
            w_j_out[i] = r_out_valid && (r_out_tag == r_qj[i]);
            w_k_cdb[i] = cdb_valid   && (cdb_tag   == r_qk[i]);
            w_k_out[i] = r_out_valid && (r_out_tag == r_qk[i]);
        end
    end

    // Scanning downwards leaves the lowest matching index as the winner.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_sel_found  = 1'b0;
        w_sel_idx    = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
            if (w_ready[i]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IDX_W'(i);
            end
        end
    end

    // Operands arriving on a bus in the insert cycle would otherwise be missed forever.
    always_comb begin
        w_in_qj_busy = in_qj_busy;
        w_in_vj      = in_vj;
        if (in_qj_busy) begin
            if (cdb_valid && (cdb_tag == in_qj)) begin
                w_in_qj_busy = 1'b0;
                w_in_vj      = cdb_value;
            end else if (r_out_valid && (r_out_tag == in_qj)) begin
                w_in_qj_busy = 1'b0;
                w_in_vj      = r_out_value;
            end
        end
        w_in_qk_busy = in_qk_busy;
        w_in_vk      = in_vk;
        if (in_qk_busy) begin
            if (cdb_valid && (cdb_tag == in_qk)) begin
                w_in_qk_busy = 1'b0;
                w_in_vk      = cdb_value;
            end else if (r_out_valid && (r_out_tag == in_qk)) begin
                w_in_qk_busy = 1'b0;
                w_in_vk      = r_out_value;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy    <= '0;
            r_qj_busy <= '0;
            r_qk_busy <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                r_type[i] <= '0;
                r_qj[i]   <= '0;
                r_qk[i]   <= '0;
                r_vj[i]   <= '0;
                r_vk[i]   <= '0;
                r_A[i]    <= '0;
                r_pc[i]   <= '0;
                r_dest[i] <= '0;
            end
        end else if (flush) begin
            r_busy <= '0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (r_busy[i] && r_qj_busy[i]) begin
                    if (w_j_cdb[i]) begin
                        r_vj[i]      <= cdb_value;
                        r_qj_busy[i] <= 1'b0;
                    end else if (w_j_out[i]) begin
                        r_vj[i]      <= r_out_value;
                        r_qj_busy[i] <= 1'b0;
                    end
                end
                if (r_busy[i] && r_qk_busy[i]) begin
                    if (w_k_cdb[i]) begin
                        r_vk[i]      <= cdb_value;
                        r_qk_busy[i] <= 1'b0;
                    end else if (w_k_out[i]) begin
                        r_vk[i]      <= r_out_value;
                        r_qk_busy[i] <= 1'b0;
                    end
                end
            end
            if (w_sel_found) begin
                r_busy[w_sel_idx] <= 1'b0;
            end
            // The free slot is never busy, so it cannot collide with wakeup or issue above.
            if (w_insert) begin
                r_busy[w_free_idx]    <= 1'b1;
                r_type[w_free_idx]    <= in_type;
                r_qj_busy[w_free_idx] <= w_in_qj_busy;
                r_qk_busy[w_free_idx] <= w_in_qk_busy;
                r_qj[w_free_idx]      <= in_qj;
                r_qk[w_free_idx]      <= in_qk;
                r_vj[w_free_idx]      <= w_in_vj;
                r_vk[w_free_idx]      <= w_in_vk;
                r_A[w_free_idx]       <= in_A;
                r_pc[w_free_idx]      <= in_pc;
                r_dest[w_free_idx]    <= in_dest;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iss_valid <= 1'b0;
            r_iss_dest  <= '0;
            r_ex_type   <= '0;
            r_ex_vj     <= '0;
            r_ex_vk     <= '0;
            r_ex_A      <= '0;
            r_ex_pc     <= '0;
        end else if (flush) begin
            r_iss_valid <= 1'b0;
        end else begin
            r_iss_valid <= w_sel_found;
            if (w_sel_found) begin
                r_iss_dest <= r_dest[w_sel_idx];
                r_ex_type  <= r_type[w_sel_idx];
                r_ex_vj    <= r_vj[w_sel_idx];
                r_ex_vk    <= r_vk[w_sel_idx];
                r_ex_A     <= r_A[w_sel_idx];
                r_ex_pc    <= r_pc[w_sel_idx];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_tag    <= '0;
            r_out_value  <= '0;
            r_out_jumppc <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_iss_valid;
            if (r_iss_valid) begin
                r_out_tag    <= r_iss_dest;
                r_out_value  <= ex_value;
                r_out_jumppc <= ex_jumppc;
            end
        end
    end

    assign ex_type    = r_ex_type;
    assign ex_vj      = r_ex_vj;
    assign ex_vk      = r_ex_vk;
    assign ex_A       = r_ex_A;
    assign ex_pc      = r_ex_pc;
    assign out_valid  = r_out_valid;
    assign out_tag    = r_out_tag;
    assign out_value  = r_out_value;
    assign out_jumppc = r_out_jumppc;

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Directed bench for alu_rs_scheduler with a small combinational EX model.
module tb_alu_rs_scheduler;

    localparam logic [5:0] T_ADD  = 6'd1;
    localparam logic [5:0] T_SUB  = 6'd2;
    localparam logic [5:0] T_ADDI = 6'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [5:0]  in_type;
    logic        in_qj_busy;
    logic        in_qk_busy;
    logic [3:0]  in_qj;
    logic [3:0]  in_qk;
    logic [31:0] in_vj;
    logic [31:0] in_vk;
    logic [31:0] in_A;
    logic [31:0] in_pc;
    logic [3:0]  in_dest;
    logic        full;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic [5:0]  ex_type;
    logic [31:0] ex_vj;
    logic [31:0] ex_vk;
    logic [31:0] ex_A;
    logic [31:0] ex_pc;
    logic [31:0] ex_value;
    logic [31:0] ex_jumppc;
    logic        out_valid;
    logic [3:0]  out_tag;
    logic [31:0] out_value;
    logic [31:0] out_jumppc;

    int checks = 0;
    int errors = 0;
    bit got;

    always #5 clk = ~clk;

    alu_rs_scheduler #(.RS_SIZE(16), .TAG_W(4), .TYPE_W(6)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_type(in_type),
        .in_qj_busy(in_qj_busy), .in_qk_busy(in_qk_busy),
        .in_qj(in_qj), .in_qk(in_qk),
        .in_vj(in_vj), .in_vk(in_vk), .in_A(in_A), .in_pc(in_pc),
        .in_dest(in_dest), .full(full),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .ex_type(ex_type), .ex_vj(ex_vj), .ex_vk(ex_vk), .ex_A(ex_A), .ex_pc(ex_pc),
        .ex_value(ex_value), .ex_jumppc(ex_jumppc),
        .out_valid(out_valid), .out_tag(out_tag),
        .out_value(out_value), .out_jumppc(out_jumppc)
    );

    // Stand-in for the single-cycle EX unit
    always_comb begin
        ex_value = 32'd0;
        case (ex_type)
            T_ADD:   ex_value = ex_vj + ex_vk;
            T_SUB:   ex_value = ex_vj - ex_vk;
            T_ADDI:  ex_value = ex_vj + ex_A;
            default: ex_value = 32'd0;
        endcase
        ex_jumppc = ex_pc + ex_A;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ins(input logic [5:0] t, input logic qjb, input logic [3:0] qj,
                       input logic [31:0] vj, input logic [31:0] vk, input logic [31:0] a,
                       input logic [31:0] pc, input logic [3:0] dest);
        in_valid   = 1'b1;
        in_type    = t;
        in_qj_busy = qjb;
        in_qj      = qj;
        in_vj      = vj;
        in_qk_busy = 1'b0;
        in_qk      = 4'd0;
        in_vk      = vk;
        in_A       = a;
        in_pc      = pc;
        in_dest    = dest;
        step();
        in_valid   = 1'b0;
    endtask

    task automatic wait_out(input int bound, output bit found);
        found = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (out_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
            step();
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_type = '0;
        in_qj_busy = 1'b0; in_qk_busy = 1'b0; in_qj = '0; in_qk = '0;
        in_vj = '0; in_vk = '0; in_A = '0; in_pc = '0; in_dest = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
        step(); step();
        rst = 1'b0;
        step();

        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_tag", {28'd0, out_tag}, 32'd0);
        chk("rst_out_value", out_value, 32'd0);
        chk("rst_out_jumppc", out_jumppc, 32'd0);
        chk("rst_ex_type", {26'd0, ex_type}, 32'd0);
        chk("rst_ex_vj", ex_vj, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);

        // Independent ADD: insert cycle 0, EX cycle 2, result cycle 3
        ins(T_ADD, 1'b0, 4'd0, 32'd5, 32'd7, 32'd4, 32'd100, 4'd3);
        chk("add_c1_out_valid", {31'd0, out_valid}, 32'd0);
        step();
        chk("add_ex_type", {26'd0, ex_type}, {26'd0, T_ADD});
        chk("add_ex_vj", ex_vj, 32'd5);
        chk("add_ex_vk", ex_vk, 32'd7);
        step();
        chk("add_out_valid", {31'd0, out_valid}, 32'd1);
        chk("add_out_tag", {28'd0, out_tag}, 32'd3);
        chk("add_out_value", out_value, 32'd12);
        chk("add_out_jumppc", out_jumppc, 32'd104);
        step();
        chk("add_single_pulse", {31'd0, out_valid}, 32'd0);

        // Wakeup via cdb two cycles after insert
        ins(T_SUB, 1'b1, 4'd6, 32'd0, 32'd1, 32'd0, 32'd0, 4'd2);
        step();
        chk("sub_waiting", {31'd0, out_valid}, 32'd0);
        cdb_valid = 1'b1; cdb_tag = 4'd6; cdb_value = 32'd10;
        step();
        cdb_valid = 1'b0;
        chk("sub_no_early", {31'd0, out_valid}, 32'd0);
        wait_out(6, got);
        chk("sub_arrived", {31'd0, got}, 32'd1);
        chk("sub_out_tag", {28'd0, out_tag}, 32'd2);
        chk("sub_out_value", out_value, 32'd9);
        step();

        // Self-forward from the ALU result bus
        ins(T_ADDI, 1'b0, 4'd0, 32'd4, 32'd0, 32'd1, 32'd0, 4'd1);
        ins(T_ADD, 1'b1, 4'd1, 32'd0, 32'd2, 32'd0, 32'd0, 4'd5);
        wait_out(8, got);
        chk("fwd1_arrived", {31'd0, got}, 32'd1);
        chk("fwd1_tag", {28'd0, out_tag}, 32'd1);
        chk("fwd1_value", out_value, 32'd5);
        step();
        wait_out(8, got);
        chk("fwd2_arrived", {31'd0, got}, 32'd1);
        chk("fwd2_tag", {28'd0, out_tag}, 32'd5);
        chk("fwd2_value", out_value, 32'd7);
        step();

        // Insert bypass from cdb in the insert cycle
        cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_value = 32'd20;
        ins(T_ADD, 1'b1, 4'd9, 32'd0, 32'd3, 32'd0, 32'd0, 4'd6);
        cdb_valid = 1'b0;
        wait_out(8, got);
        chk("byp_cdb_arrived", {31'd0, got}, 32'd1);
        chk("byp_cdb_tag", {28'd0, out_tag}, 32'd6);
        chk("byp_cdb_value", out_value, 32'd23);
        step();

        // Insert bypass from own result bus in the insert cycle
        ins(T_ADDI, 1'b0, 4'd0, 32'd30, 32'd0, 32'd0, 32'd0, 4'd10);
        step(); step();
        chk("byp_own_prod_tag", {28'd0, out_tag}, 32'd10);
        chk("byp_own_prod_valid", {31'd0, out_valid}, 32'd1);
        ins(T_ADD, 1'b1, 4'd10, 32'd0, 32'd1, 32'd0, 32'd0, 4'd11);
        wait_out(8, got);
        chk("byp_own_arrived", {31'd0, got}, 32'd1);
        chk("byp_own_tag", {28'd0, out_tag}, 32'd11);
        chk("byp_own_value", out_value, 32'd31);
        step();

        // Fill all 16 entries (held on tag 15), drop a 17th, then release
        for (int i = 0; i < 16; i++) begin
            ins(T_ADD, 1'b1, 4'd15, 32'd0, i, 32'd0, 32'd0, 4'(i));
        end
        chk("fill_full", {31'd0, full}, 32'd1);
        ins(T_ADD, 1'b0, 4'd0, 32'd999, 32'd0, 32'd0, 32'd0, 4'd7);
        chk("fill_full_after_drop", {31'd0, full}, 32'd1);
        chk("fill_no_issue", {31'd0, out_valid}, 32'd0);
        cdb_valid = 1'b1; cdb_tag = 4'd15; cdb_value = 32'd100;
        step();
        cdb_valid = 1'b0;
        chk("fill_full_woken", {31'd0, full}, 32'd1);
        step();
        chk("fill_full_drop", {31'd0, full}, 32'd0);
        wait_out(4, got);
        chk("fill_arrived", {31'd0, got}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk("fill_order_valid", {31'd0, out_valid}, 32'd1);
            chk("fill_order_tag", {28'd0, out_tag}, i);
            chk("fill_order_value", out_value, 32'd100 + i);
            step();
        end
        chk("fill_dropped_absent", {31'd0, out_valid}, 32'd0);
        step();
        chk("fill_dropped_absent2", {31'd0, out_valid}, 32'd0);

        // Flush with four waiting entries and one in the issue register
        for (int i = 0; i < 4; i++) begin
            ins(T_ADD, 1'b1, 4'd12, 32'd0, 32'd1, 32'd0, 32'd0, 4'(9 + i));
        end
        ins(T_ADD, 1'b0, 4'd0, 32'd1, 32'd1, 32'd0, 32'd0, 4'd8);
        step();
        chk("flush_iss_loaded", {26'd0, ex_type}, {26'd0, T_ADD});
        chk("flush_iss_vj", ex_vj, 32'd1);
        flush = 1'b1;
        cdb_valid = 1'b1; cdb_tag = 4'd12; cdb_value = 32'd50;
        step();
        flush = 1'b0;
        cdb_valid = 1'b0;
        chk("flush_full", {31'd0, full}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("flush_quiet", {31'd0, out_valid}, 32'd0);
            step();
        end
        cdb_valid = 1'b1; cdb_tag = 4'd12; cdb_value = 32'd50;
        step();
        cdb_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("flush_no_ghost", {31'd0, out_valid}, 32'd0);
            step();
        end
        ins(T_ADD, 1'b0, 4'd0, 32'd5, 32'd6, 32'd0, 32'd0, 4'd4);
        wait_out(6, got);
        chk("flush_after_arrived", {31'd0, got}, 32'd1);
        chk("flush_after_tag", {28'd0, out_tag}, 32'd4);
        chk("flush_after_value", out_value, 32'd11);
        step();

        // Reset mid-stream with three waiting entries and a live result
        for (int i = 0; i < 3; i++) begin
            ins(T_ADD, 1'b1, 4'd13, 32'd0, 32'd0, 32'd0, 32'd0, 4'(i));
        end
        ins(T_ADD, 1'b0, 4'd0, 32'd2, 32'd3, 32'd8, 32'd40, 4'd14);
        step(); step();
        chk("mid_out_valid", {31'd0, out_valid}, 32'd1);
        chk("mid_out_tag", {28'd0, out_tag}, 32'd14);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_out_tag", {28'd0, out_tag}, 32'd0);
        chk("mid_rst_out_value", out_value, 32'd0);
        chk("mid_rst_out_jumppc", out_jumppc, 32'd0);
        chk("mid_rst_ex_type", {26'd0, ex_type}, 32'd0);
        chk("mid_rst_ex_A", ex_A, 32'd0);
        chk("mid_rst_ex_pc", ex_pc, 32'd0);
        chk("mid_rst_full", {31'd0, full}, 32'd0);
        step();
        rst = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 4'd13; cdb_value = 32'd1;
        step();
        cdb_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("mid_rst_quiet", {31'd0, out_valid}, 32'd0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
